sw_capture_sequencer: RTL and testbench

- Sits directly downstream of the testing_get_data software register (PPC-to-fabric) in the user_clk domain.
- Decodes the 32-bit control word that software writes.
- Generates an edge-qualified arm/clear, then runs a snapshot capture state machine.
- Drives write-enable and address to a sample BRAM, plus a status word returned to software via a fabric-to-PPC register.

---
 rtl/sw_capture_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_sw_capture_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_capture_sequencer.sv
// rtl/sw_capture_sequencer.sv - control-word qualified snapshot capture sequencer (optional TRIG_DELAY_EN)
module sw_capture_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int STABLE_CYC = 2
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_word,
  input  logic              trig_in,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_word
);
  localparam int            SC       = (STABLE_CYC < 1) ? 1 : STABLE_CYC;
  localparam int            CW       = $clog2(SC + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(SC);
  localparam int            MAXLEN   = (1 << ADDR_W) - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Qualification of the software word
  logic [31:0]       ctrl_q;
  logic [CW-1:0]     stab_q, stab_d;
  logic              stable;
  logic              q_arm_q, q_clr_q, q_cont_q;
  logic              arm_prev_q, clr_prev_q;
  logic [15:0]       q_len_q;
  logic              arm_pulse, clr_pulse;
  logic [ADDR_W-1:0] len_sat;

  // Capture state machine and registered outputs
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d;
  logic              done_q, done_d, we_q, we_d, busy_q, busy_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       status_q, status_d;
  logic              go_cap;

`ifdef TRIG_DELAY_EN
  logic [7:0] q_dly_q;
  logic       dly_act_q, dly_act_d;
  logic [7:0] dly_cnt_q, dly_cnt_d;
  logic       start_dly;
`endif

  assign stable = (stab_q == STAB_MAX);

  // Count consecutive identical registered samples, saturating once the word is trusted
  always_comb begin
    stab_d = stab_q;
    if (ctrl_word != ctrl_q) stab_d = CW'(1);
    else if (!stable)        stab_d = stab_q + CW'(1);
  end

  // Sample the word, accept it once stable, and remember last qualified bits for edge detect
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ctrl_q     <= '0;
      stab_q     <= '0;
      q_arm_q    <= 1'b0;
      q_clr_q    <= 1'b0;
      q_cont_q   <= 1'b0;
      q_len_q    <= '0;
      arm_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
`ifdef TRIG_DELAY_EN
      q_dly_q    <= '0;
`endif
    end else begin
      ctrl_q     <= ctrl_word;
      stab_q     <= stab_d;
      arm_prev_q <= q_arm_q;
      clr_prev_q <= q_clr_q;
      if (stable) begin
        q_arm_q  <= ctrl_q[0];
        q_clr_q  <= ctrl_q[1];
        q_cont_q <= ctrl_q[2];
        q_len_q  <= ctrl_q[31:16];
`ifdef TRIG_DELAY_EN
        q_dly_q  <= ctrl_q[15:8];
`endif
      end
    end
  end

  assign arm_pulse = q_arm_q & ~arm_prev_q;
  assign clr_pulse = q_clr_q & ~clr_prev_q;
  assign len_sat   = ({1'b0, q_len_q} > 17'(MAXLEN)) ? ADDR_W'(MAXLEN) : ADDR_W'(q_len_q);

`ifdef TRIG_DELAY_EN
  // Leave WAIT_TRIG at the end of the delay count, or directly on a trigger with zero delay
  always_comb begin
    start_dly = !dly_act_q && trig_in && (q_dly_q != 8'd0);
    go_cap    = dly_act_q ? (dly_cnt_q == 8'd1) : (trig_in && (q_dly_q == 8'd0));
  end
`else
  assign go_cap = trig_in;
`endif

  // State and registered outputs
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      status_q  <= '0;
`ifdef TRIG_DELAY_EN
      dly_act_q <= 1'b0;
      dly_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      done_q    <= done_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      status_q  <= status_d;
`ifdef TRIG_DELAY_EN
      dly_act_q <= dly_act_d;
      dly_cnt_q <= dly_cnt_d;
`endif
    end
  end

  // Next state: clear overrides everything; arm is only honoured from IDLE or DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arm_pulse) state_d = S_WAIT;
      S_WAIT: if (go_cap) state_d = S_CAP;
      S_CAP:  if (addr_q == len_q) state_d = S_DONE;
      S_DONE: if (arm_pulse || q_cont_q) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (clr_pulse) state_d = S_IDLE;
  end

  // Datapath and output values loaded alongside the next state
  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    done_d  = done_q;
    count_d = count_q;
    if (clr_pulse) begin
      addr_d  = '0;
      done_d  = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (arm_pulse) begin
          addr_d  = '0;
          done_d  = 1'b0;
          count_d = '0;
          len_d   = len_sat;
        end
        S_WAIT: if (state_d == S_CAP) done_d = 1'b0;
        S_CAP: begin
          count_d = 16'(addr_q) + 16'd1;
          if (addr_q == len_q) done_d = 1'b1;
          else                 addr_d = addr_q + ADDR_W'(1);
        end
        S_DONE: if (arm_pulse) begin
          addr_d  = '0;
          done_d  = 1'b0;
          count_d = '0;
          len_d   = len_sat;
        end else if (q_cont_q) begin
          // continuous re-arm keeps done and the last count visible until the next capture starts
          addr_d = '0;
          len_d  = len_sat;
        end
        default: ;
      endcase
    end
    we_d     = (state_d == S_CAP);
    busy_d   = (state_d == S_WAIT) || (state_d == S_CAP);
    status_d = {done_d, busy_d, state_d, 12'b0, count_d};
`ifdef TRIG_DELAY_EN
    dly_act_d = dly_act_q;
    dly_cnt_d = dly_cnt_q;
    if (state_q == S_WAIT) begin
      if (dly_act_q) dly_cnt_d = dly_cnt_q - 8'd1;
      else if (start_dly) begin
        dly_act_d = 1'b1;
        dly_cnt_d = q_dly_q;
      end
    end
    if (state_d != S_WAIT) dly_act_d = 1'b0;
`endif
  end

  assign bram_we     = we_q;
  assign bram_addr   = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status_word = status_q;

endmodule

// File: tb/tb_sw_capture_sequencer.sv
// tb/tb_sw_capture_sequencer.sv - randomized self-checking bench for sw_capture_sequencer
`timescale 1ns/1ps
module tb_sw_capture_sequencer;
  localparam int ADDR_W     = 10;
  localparam int STABLE_CYC = 2;
  localparam int DEPTH      = 1 << ADDR_W;
`ifdef TRIG_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [31:0]       ctrl_word;
  logic              trig_in;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic              busy;
  logic              done;
  logic [31:0]       status_word;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_addr[$];
  int wr_cyc[$];

  sw_capture_sequencer #(.ADDR_W(ADDR_W), .STABLE_CYC(STABLE_CYC)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl_word  (ctrl_word),
    .trig_in    (trig_in),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .busy       (busy),
    .done       (done),
    .status_word(status_word)
  );

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Record every write with the cycle it occupied
  always @(negedge user_clk) begin
    if (user_rst === 1'b0 && bram_we === 1'b1) begin
      wr_addr.push_back(int'(bram_addr));
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge user_clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] w);
    @(posedge user_clk);
    #1 ctrl_word = w;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge user_clk);
  endtask

  task automatic disarm();
    drive_word(32'h0);
    settle(STABLE_CYC + 3);
  endtask

  // Word change -> qualified after STABLE_CYC samples -> pulse -> busy one cycle later
  task automatic arm(input logic [31:0] w, input bit glitch_en, input logic [31:0] glitch);
    int c0;
    int seen;
    if (glitch_en) drive_word(glitch);
    drive_word(w);
    c0   = cyc;
    seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      sample();
      if (busy === 1'b1) seen = cyc - c0;
    end
    check("arm_latency", 32'(seen), 32'(STABLE_CYC + 2));
  endtask

  task automatic fire(input int hold, output int tc);
    @(posedge user_clk);
    #1 trig_in = 1'b1;
    tc = cyc;
    repeat (hold) @(posedge user_clk);
    #1 trig_in = 1'b0;
  endtask

  // Reference: min(len, DEPTH-1)+1 writes at addresses 0.., contiguous, starting the
  // cycle after the trigger sample plus the delay when the delay feature exists
  task automatic capture(input string tag, input int len, input int dly, input int hold);
    int n, d, tc, bad, waited, budget, first;
    n      = (len > DEPTH - 1) ? DEPTH : len + 1;
    d      = DELAY_EN ? dly : 0;
    budget = n + dly + hold + 40;
    wr_addr.delete();
    wr_cyc.delete();
    fire(hold, tc);
    first  = tc + 1 + d;
    waited = 0;
    while (!(wr_addr.size() >= n && bram_we === 1'b0) && waited < budget) begin
      sample();
      waited++;
    end
    check({tag, "_timeout"}, 32'(waited >= budget), 32'd0);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_cyc[i] != first + i) bad++;
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n));
    check({tag, "_order"}, 32'(bad), 32'd0);
    check({tag, "_first_cyc"}, 32'((wr_cyc.size() > 0) ? wr_cyc[0] : -1), 32'(first));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_status"}, status_word, 32'h8000_0000 | 32'h3000_0000 | 32'(n));
  endtask

  initial begin
    int tc, waited, nb;
    ctrl_word = 32'h0;
    trig_in   = 1'b0;
    user_rst  = 1'b1;
    settle(2);
    #1;
    check("rst_we",     32'(bram_we),   32'd0);
    check("rst_addr",   32'(bram_addr), 32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_status", status_word,    32'd0);
    @(negedge user_clk) user_rst = 1'b0;

    // Idle with a zero word: nothing must happen
    settle(20);
    sample();
    check("idle_writes", 32'(wr_addr.size()), 32'd0);
    check("idle_status", status_word, 32'd0);

    // Single capture, len 7
    arm(32'h0007_0001, 1'b0, 32'h0);
    sample();
    check("wait_status", status_word, 32'h5000_0000);
    capture("len7", 7, 0, 1);

    // Torn word: intermediate value must not produce its own arm
    disarm();
    arm(32'h0003_0001, 1'b1, 32'h0003_0000);
    capture("torn", 3, 0, 1);

    // Clear during a long capture
    disarm();
    arm(32'h0064_0001, 1'b0, 32'h0);
    wr_addr.delete();
    wr_cyc.delete();
    fire(1, tc);
    waited = 0;
    while (wr_addr.size() < 10 && waited < 200) begin
      sample();
      waited++;
    end
    drive_word(32'h0064_0003);
    waited = 0;
    while (bram_we !== 1'b0 && waited < 20) begin
      sample();
      waited++;
    end
    check("clr_nwrites", 32'(wr_addr.size()), 32'(10 + STABLE_CYC + 2));
    check("clr_addr",    32'(bram_addr), 32'd0);
    check("clr_done",    32'(done), 32'd0);
    check("clr_status",  status_word, 32'd0);

    // Continuous mode: two captures from one arm, re-arm while busy ignored
    disarm();
    arm(32'h0003_0005, 1'b0, 32'h0);
    capture("cont1", 3, 0, 1);
    sample();
    check("cont_rearm_busy", 32'(busy), 32'd1);
    check("cont_rearm_done", 32'(done), 32'd1);
    drive_word(32'h0003_0004);
    settle(STABLE_CYC + 3);
    drive_word(32'h0003_0005);
    settle(STABLE_CYC + 3);
    sample();
    check("busy_arm_ignored_done", 32'(done), 32'd1);
    check("busy_arm_ignored_busy", 32'(busy), 32'd1);
    capture("cont2", 3, 0, 2);
    drive_word(32'h0003_0007);
    settle(STABLE_CYC + 3);
    sample();
    check("cont_clr_status", status_word, 32'd0);

    // Trigger delay 5, len 2
    disarm();
    arm(32'h0002_0501, 1'b0, 32'h0);
    capture("delay5", 2, 5, 1);

    // Clear and arm qualifying together: clear wins
    disarm();
    nb = wr_addr.size();
    drive_word(32'h0005_0003);
    settle(STABLE_CYC + 4);
    sample();
    check("clr_arm_status", status_word, 32'd0);
    check("clr_arm_writes", 32'(wr_addr.size()), 32'(nb));

    // Randomized captures with a one-cycle glitch before each word
    for (int k = 0; k < 4; k++) begin
      int len, dly, hold, flip;
      logic [31:0] w;
      len  = (k == 0) ? 0 : int'($urandom_range(1, 40));
      dly  = (k == 1) ? 0 : int'($urandom_range(1, 6));
      hold = int'($urandom_range(1, 4));
      flip = int'($urandom_range(1, 65535));
      w    = {16'(len), 8'(dly), 8'h01};
      disarm();
      arm(w, 1'b1, w ^ {16'(flip), 16'h0000});
      capture("rand", len, dly, hold);
    end

    // Length saturates at full depth
    disarm();
    arm(32'hFFFF_0001, 1'b0, 32'h0);
    capture("sat", 32'hFFFF, 0, 1);

    // Reset in the middle of a capture
    disarm();
    arm(32'h0032_0001, 1'b0, 32'h0);
    fire(1, tc);
    settle(5);
    #3;
    user_rst  = 1'b1;
    ctrl_word = 32'h0;
    #1;
    check("midrst_we",     32'(bram_we),   32'd0);
    check("midrst_addr",   32'(bram_addr), 32'd0);
    check("midrst_busy",   32'(busy),      32'd0);
    check("midrst_status", status_word,    32'd0);
    nb = wr_addr.size();
    settle(3);
    @(negedge user_clk) user_rst = 1'b0;
    settle(10);
    sample();
    check("midrst_nowrites", 32'(wr_addr.size()), 32'(nb));
    check("midrst_idle",     status_word, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
